// File: rtl/hangman_pkg.sv
// Shared constants and state types for the hangman word transmitter.
// WORD_TX_CHECKSUM_EN adds the SEND_CSUM state to word_tx_state_t.
package hangman_pkg;

  localparam logic [7:0] WORD_TX_START    = 8'h02;
  localparam logic [7:0] WORD_TX_END      = 8'h03;
  localparam logic [7:0] WORD_TX_EOG      = 8'h04;
  localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;

  typedef enum logic [2:0] {
    IDLE,
    SEND_START,
    SEND_BODY,
`ifdef WORD_TX_CHECKSUM_EN
    SEND_CSUM,
`endif
    SEND_END,
    SEND_EOG,
    WAIT_ACK
  } word_tx_state_t;

  // WAIT_ACK is split in two so each byte needs a full busy/idle cycle of the UART.
  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_WAIT_LOW,
    ISS_WAIT_HIGH
  } tx_issue_state_t;

endpackage

// File: rtl/tx_byte_issuer.sv
// Single-byte UART loader: pulses txclk once per accepted request, then waits
// for txready to fall and rise again before reporting done.
module tx_byte_issuer
  import hangman_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  input  logic       txready_i,
  output logic [7:0] txdata_o,
  output logic       txclk_o,
  output logic       issued_o,
  output logic       done_o
);

  tx_issue_state_t state_q, state_d;
  logic [7:0]      txdata_q;
  logic            txclk_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= ISS_IDLE;
      txdata_q <= 8'h00;
      txclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      txclk_q <= issued_o;
      if (issued_o) txdata_q <= byte_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    issued_o = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      ISS_IDLE: begin
        if (req_i && txready_i) begin
          issued_o = 1'b1;
          state_d  = ISS_WAIT_LOW;
        end
      end
      ISS_WAIT_LOW: begin
        if (!txready_i) state_d = ISS_WAIT_HIGH;
      end
      ISS_WAIT_HIGH: begin
        if (txready_i) begin
          done_o  = 1'b1;
          state_d = ISS_IDLE;
        end
      end
      default: state_d = ISS_IDLE;
    endcase
  end

  assign txdata_o = txdata_q;
  assign txclk_o  = txclk_q;

endmodule

// File: rtl/word_tx_packer.sv
// Buffers keypad letters and ships them as START/letters/END frames over the UART,
// plus a standalone end-of-game byte. WORD_TX_CHECKSUM_EN inserts an XOR checksum byte.
module word_tx_packer
  import hangman_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 8,
  parameter logic [7:0]  START_BYTE = WORD_TX_START,
  parameter logic [7:0]  END_BYTE   = WORD_TX_END,
  parameter logic [7:0]  EOG_BYTE   = WORD_TX_EOG
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       letter_valid,
  input  logic [7:0] letter,
  input  logic       word_submit,
  input  logic       game_end,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic [3:0] word_len,
  output logic       overflow
);

  localparam int unsigned IDXW      = $clog2(MAX_LEN);
  localparam logic [3:0]  MAX_LEN_W = 4'(MAX_LEN);
`ifdef WORD_TX_CHECKSUM_EN
  localparam word_tx_state_t TAIL_STATE = SEND_CSUM;
`else
  localparam word_tx_state_t TAIL_STATE = SEND_END;
`endif

  word_tx_state_t state_q, state_d;
  word_tx_state_t after_q, after_d;
  logic [3:0]     wordLen_q, wordLen_d;
  logic [3:0]     bodyIdx_q, bodyIdx_d;
  logic           overflow_q, overflow_d;
  logic           pendEog_q, pendEog_d;
  logic           lastEog_q, lastEog_d;
`ifdef WORD_TX_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif
  logic [7:0]     wordBuf [MAX_LEN];
  logic           bufWe;
  logic           req;
  logic [7:0]     reqByte;
  logic           issued;
  logic           done;

  tx_byte_issuer uIssuer (
    .clk       (clk),
    .nRst      (nRst),
    .req_i     (req),
    .byte_i    (reqByte),
    .txready_i (txready),
    .txdata_o  (txdata),
    .txclk_o   (txclk),
    .issued_o  (issued),
    .done_o    (done)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      after_q    <= IDLE;
      wordLen_q  <= 4'd0;
      bodyIdx_q  <= 4'd0;
      overflow_q <= 1'b0;
      pendEog_q  <= 1'b0;
      lastEog_q  <= 1'b0;
`ifdef WORD_TX_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      after_q    <= after_d;
      wordLen_q  <= wordLen_d;
      bodyIdx_q  <= bodyIdx_d;
      overflow_q <= overflow_d;
      pendEog_q  <= pendEog_d;
      lastEog_q  <= lastEog_d;
`ifdef WORD_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Letter storage needs no reset: word_len alone says which entries are live.
  always_ff @(posedge clk) begin
    if (bufWe) wordBuf[wordLen_q[IDXW-1:0]] <= letter;
  end

  always_comb begin
    state_d    = state_q;
    after_d    = after_q;
    wordLen_d  = wordLen_q;
    bodyIdx_d  = bodyIdx_q;
    overflow_d = overflow_q;
    pendEog_d  = pendEog_q;
    lastEog_d  = lastEog_q;
`ifdef WORD_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    bufWe      = 1'b0;
    req        = 1'b0;
    reqByte    = 8'h00;

    if (letter_valid) begin
      if (state_q == IDLE && wordLen_q < MAX_LEN_W) begin
        bufWe     = 1'b1;
        wordLen_d = wordLen_q + 4'd1;
`ifdef WORD_TX_CHECKSUM_EN
        csum_d    = csum_q ^ letter;
`endif
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (state_q == SEND_EOG && issued) pendEog_d = 1'b0;
    if (game_end) pendEog_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (word_submit) state_d = SEND_START;
        else if (pendEog_q) state_d = SEND_EOG;
      end
      SEND_START: begin
        req     = 1'b1;
        reqByte = START_BYTE;
        if (issued) begin
          state_d   = WAIT_ACK;
          bodyIdx_d = 4'd0;
          after_d   = (wordLen_q != 4'd0) ? SEND_BODY : TAIL_STATE;
        end
      end
      SEND_BODY: begin
        req     = 1'b1;
        reqByte = wordBuf[bodyIdx_q[IDXW-1:0]];
        if (issued) begin
          state_d   = WAIT_ACK;
          bodyIdx_d = bodyIdx_q + 4'd1;
          after_d   = (bodyIdx_q == wordLen_q - 4'd1) ? TAIL_STATE : SEND_BODY;
        end
      end
`ifdef WORD_TX_CHECKSUM_EN
      SEND_CSUM: begin
        req     = 1'b1;
        reqByte = csum_q;
        if (issued) begin
          state_d = WAIT_ACK;
          after_d = SEND_END;
        end
      end
`endif
      SEND_END: begin
        req     = 1'b1;
        reqByte = END_BYTE;
        if (issued) begin
          state_d   = WAIT_ACK;
          after_d   = IDLE;
          lastEog_d = 1'b0;
        end
      end
      SEND_EOG: begin
        req     = 1'b1;
        reqByte = EOG_BYTE;
        if (issued) begin
          state_d   = WAIT_ACK;
          after_d   = IDLE;
          lastEog_d = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (done) begin
          state_d = after_q;
          // Only a finished word frame empties the buffer; the EOG byte leaves it alone.
          if (after_q == IDLE && !lastEog_q) begin
            wordLen_d  = 4'd0;
            overflow_d = 1'b0;
`ifdef WORD_TX_CHECKSUM_EN
            csum_d     = 8'h00;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign word_len = wordLen_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_word_tx_packer.sv
// Scoreboard bench for word_tx_packer: a frame-level model queues expected UART bytes
// and a monitor pops them on every txclk; a small UART model toggles txready.
module tb_word_tx_packer;

  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       letter_valid = 1'b0;
  logic [7:0] letter = 8'h00;
  logic       word_submit = 1'b0;
  logic       game_end = 1'b0;
  logic       txready;
  logic [7:0] txdata;
  logic       txclk;
  logic       busy;
  logic [3:0] word_len;
  logic       overflow;

  logic       uartReady = 1'b1;
  logic       forceLow = 1'b0;
  assign txready = uartReady & ~forceLow;

  int total = 0;
  int bad = 0;
  int rxCount = 0;
  logic [7:0] expQ[$];
  logic [7:0] modelBuf[$];
  logic       modelOvf = 1'b0;

  word_tx_packer #(.MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .letter_valid (letter_valid),
    .letter       (letter),
    .word_submit  (word_submit),
    .game_end     (game_end),
    .txready      (txready),
    .txdata       (txdata),
    .txclk        (txclk),
    .busy         (busy),
    .word_len     (word_len),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every txclk pulse must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (nRst && txclk) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_byte: got %02h expected none", txdata);
        end else begin
          checkOutput("tx_byte", {24'h0, txdata}, {24'h0, expQ.pop_front()});
        end
        rxCount++;
      end
    end
  end

  // UART model: goes busy for a random 1..4 cycles after each load strobe.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        uartReady = 1'b1;
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) uartReady = 1'b1;
      end else if (txclk) begin
        uartReady = 1'b0;
        cnt = $urandom_range(1, 4);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushFrame();
    logic [7:0] x;
    x = 8'h00;
    expQ.push_back(8'h02);
    foreach (modelBuf[i]) begin
      expQ.push_back(modelBuf[i]);
      x = x ^ modelBuf[i];
    end
`ifdef WORD_TX_CHECKSUM_EN
    expQ.push_back(x);
`endif
    expQ.push_back(8'h03);
    modelBuf.delete();
    modelOvf = 1'b0;
  endtask

  // Drives one cycle of strobes and records what the specification says must follow.
  task automatic applyStimulus(input logic lv, input logic [7:0] ch, input logic ws, input logic ge);
    letter_valid = lv;
    letter       = ch;
    word_submit  = ws;
    game_end     = ge;
    tick();
    letter_valid = 1'b0;
    word_submit  = 1'b0;
    game_end     = 1'b0;
    if (lv) begin
      if (modelBuf.size() < MAX_LEN) modelBuf.push_back(ch);
      else modelOvf = 1'b1;
    end
    if (ws) pushFrame();
    if (ge) expQ.push_back(8'h04);
  endtask

  task automatic sendWord(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(1'b1, s[i], 1'b0, 1'b0);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || expQ.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d bytes pending expected 0", name, expQ.size());
      expQ.delete();
    end
    tick();
  endtask

  task automatic waitRx(input int target, input string name);
    int n = 0;
    while (rxCount < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d bytes expected %0d", name, rxCount, target);
    end
  endtask

  task automatic checkIdleState(input string name);
    checkOutput({name, "_len"}, {28'h0, word_len}, modelBuf.size());
    checkOutput({name, "_ovf"}, {31'h0, overflow}, {31'h0, modelOvf});
  endtask

  initial begin
    int base;
    int len;
    logic combine;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_txdata", {24'h0, txdata}, 32'h0);
    checkOutput("rst_txclk", {31'h0, txclk}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_len", {28'h0, word_len}, 32'h0);
    checkOutput("rst_ovf", {31'h0, overflow}, 32'h0);
    nRst = 1'b1;
    tick();

    // CAT, with the two-cycle submit-to-txclk latency
    sendWord("CAT");
    checkIdleState("cat_pre");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("cat_busy", {31'h0, busy}, 32'h1);
    tick();
    checkOutput("cat_latency", {31'h0, txclk}, 32'h1);
    waitIdle("cat");
    checkIdleState("cat_post");

    // One letter too many
    for (int i = 0; i < MAX_LEN + 1; i++) applyStimulus(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
    checkIdleState("full_pre");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    waitIdle("full");
    checkIdleState("full_post");

    // Letter and submit together on an empty buffer
    applyStimulus(1'b1, "Z", 1'b1, 1'b0);
    waitIdle("z");
    checkIdleState("z_post");

    // Empty word
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    waitIdle("empty");

    // game_end mid-frame, alone, and together with submit
    sendWord("HELLO");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    base = rxCount;
    waitRx(base + 3, "eog_mid");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    waitIdle("eog_mid");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    waitIdle("eog_alone");
    sendWord("OK");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    waitIdle("eog_same");
    checkIdleState("eog_post");

    // txready held low mid-frame
    sendWord("STALL");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    base = rxCount;
    waitRx(base + 3, "stall");
    forceLow = 1'b1;
    base = rxCount;
    repeat (50) @(negedge clk);
    checkOutput("stall_no_txclk", rxCount - base, 32'h0);
    forceLow = 1'b0;
    waitIdle("stall");

    // Reset in the middle of a frame
    sendWord("RSTU");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    base = rxCount;
    waitRx(base + 2, "abort");
    nRst = 1'b0;
    #1;
    checkOutput("abort_txclk", {31'h0, txclk}, 32'h0);
    checkOutput("abort_txdata", {24'h0, txdata}, 32'h0);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    checkOutput("abort_len", {28'h0, word_len}, 32'h0);
    checkOutput("abort_ovf", {31'h0, overflow}, 32'h0);
    expQ.delete();
    modelBuf.delete();
    modelOvf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRst = 1'b1;
    tick();
    sendWord("NEW");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    waitIdle("fresh");

    // Random words, sometimes overfull, sometimes with the last letter on the submit cycle
    for (int w = 0; w < 12; w++) begin
      len = $urandom_range(0, MAX_LEN + 2);
      combine = ($urandom_range(0, 3) == 0) && (len > 0);
      for (int i = 0; i < len - (combine ? 1 : 0); i++)
        applyStimulus(1'b1, 8'h41 + 8'($urandom_range(0, 25)), 1'b0, 1'b0);
      checkIdleState("rand_pre");
      applyStimulus(combine, 8'h41 + 8'($urandom_range(0, 25)), 1'b1, 1'b0);
      waitIdle("rand");
      checkIdleState("rand_post");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
